// File: rtl/alu_seq_pkg.sv
// Shared types and opcode map for the ALU step sequencer.
package alu_seq_pkg;

    // FSM T-states; ERR is a single-cycle reject of an unsupported opcode.
    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        ERR
    } state_t;

    // Opcode field INSTR[9:6]; doubles as the ALU function code.
    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_COPY = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_NEG  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SHL  = 4'b1001;
    localparam logic [3:0] OP_SHR  = 4'b1010;
    localparam logic [3:0] OP_ASR  = 4'b1011;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_SUBI = 4'b1101;

    // Step-pattern class: which T-state sequence an opcode follows.
    typedef enum logic [2:0] {
        CL_L,    // load immediate into G, then write Rx
        CL_S,    // shift Ry through G, then write Rx
        CL_U,    // unary on Ry via A, idle-bus G capture, write Rx
        CL_B,    // binary Rx op Ry: Ry into A, Rx on bus into G, write Rx
        CL_I,    // immediate into A, Rx on bus into G, write Rx
        CL_BAD   // unsupported opcode
    } opclass_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode -> step-pattern class lookup.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output opclass_t   opclass
);

    // Map each opcode to its sequence class; 1110/1111 fall to CL_BAD.
    always_comb begin
        opclass = CL_BAD;
        case (opcode)
            OP_LOAD:                                 opclass = CL_L;
            OP_SHL, OP_SHR, OP_ASR:                  opclass = CL_S;
            OP_COPY, OP_NEG, OP_NOT:                 opclass = CL_U;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:   opclass = CL_B;
            OP_ADDI, OP_SUBI:                        opclass = CL_I;
            default:                                 opclass = CL_BAD;
        endcase
    end

endmodule

// File: rtl/alu_step_sequencer.sv
// Multi-cycle control FSM for the 10-bit datapath. Controls are a Moore
// decode of {state, IR}: they settle after posedge and are captured by the
// datapath on the following negedge.
module alu_step_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int FN_W  = 4
) (
    input  logic             CLKb,
    input  logic             RSTb,
    input  logic             EXEC,
    input  logic [9:0]       INSTR,
    output logic [FN_W-1:0]  FN,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             Extern,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    state_t         state, state_nx;
    logic [9:0]     ir;
    opclass_t       ir_cl, in_cl;
    logic [NREGS-1:0] rx_oh, ry_oh;

    // Class of the incoming word decides T1 vs ERR at accept time;
    // class of the latched word drives the step pattern.
    alu_seq_decode u_dec_in (.opcode(INSTR[9:6]), .opclass(in_cl));
    alu_seq_decode u_dec_ir (.opcode(ir[9:6]),    .opclass(ir_cl));

    assign rx_oh = NREGS'(1) << ir[5:3];
    assign ry_oh = NREGS'(1) << ir[2:0];

    // State register and instruction latch; IR loads only on an IDLE accept.
    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && EXEC)
                ir <= INSTR;
        end
    end

    // Next-state and control decode; at most one bus driver per state.
    always_comb begin
        state_nx = state;
        FN       = '0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        Extern   = 1'b0;
        Done     = 1'b0;
        Err      = 1'b0;
        Busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (EXEC)
                    state_nx = (in_cl == CL_BAD) ? ERR : T1;
            end
            T1: begin
                FN       = FN_W'(ir[9:6]);
                state_nx = T2;
                case (ir_cl)
                    CL_L:       begin Extern = 1'b1; Gin = 1'b1; end
                    CL_S:       begin Rout = ry_oh;  Gin = 1'b1; end
                    CL_U, CL_B: begin Rout = ry_oh;  Ain = 1'b1; end
                    CL_I:       begin Extern = 1'b1; Ain = 1'b1; end
                    default:    state_nx = IDLE;
                endcase
            end
            T2: begin
                FN = FN_W'(ir[9:6]);
                case (ir_cl)
                    CL_L, CL_S: begin
                        Gout = 1'b1; Rin = rx_oh; Done = 1'b1;
                        state_nx = IDLE;
                    end
                    // Unary result is already in A's path; bus stays undriven.
                    CL_U: begin
                        Gin = 1'b1;
                        state_nx = T3;
                    end
                    CL_B, CL_I: begin
                        Rout = rx_oh; Gin = 1'b1;
                        state_nx = T3;
                    end
                    default: state_nx = IDLE;
                endcase
            end
            T3: begin
                FN   = FN_W'(ir[9:6]);
                Gout = 1'b1;
                Rin  = rx_oh;
                Done = 1'b1;
                state_nx = IDLE;
            end
            ERR: begin
                Done = 1'b1;
                Err  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
